// File: rtl/bp_pkg.sv
// Shared constants and index hash for the branch predictor.
// Gshare indexing is selected by the BP_GSHARE_EN macro in branch_predictor.
package bp_pkg;

  localparam logic [1:0] SN = 2'b00;
  localparam logic [1:0] WN = 2'b01;
  localparam logic [1:0] WT = 2'b10;
  localparam logic [1:0] ST = 2'b11;

  // Word-aligned PC folded with (zero-extended) history; caller truncates to IDX_BITS.
  function automatic logic [31:0] bp_hash(input logic [31:0] pc, input logic [31:0] ghr);
    return (pc >> 2) ^ ghr;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-state logic (SN/WN/WT/ST).
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != ST) cnt_next = cnt + 2'd1;
    end else begin
      if (cnt != SN) cnt_next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal PHT + direct-mapped BTB predictor with combinational lookup.
// Define BP_GSHARE_EN to fold a global history register into the index.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int IDX_BITS = 6,
  parameter int GHR_BITS = 6,
  parameter int TAG_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcF,
  output logic        predTakenF,
  output logic [31:0] predTargetF,
  input  logic        updEn,
  input  logic [31:0] updPc,
  input  logic        updTaken,
  input  logic [31:0] updTarget,
  input  logic        updMispredict,
  output logic [31:0] missCount
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0]          pht        [ENTRIES];
  logic [ENTRIES-1:0]  btb_valid;
  logic [TAG_BITS-1:0] btb_tag    [ENTRIES];
  logic [31:0]         btb_target [ENTRIES];

  logic [31:0]         ghr_ext;
  logic [IDX_BITS-1:0] fetch_idx;
  logic [IDX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0] fetch_tag;
  logic [TAG_BITS-1:0] upd_tag;
  logic [1:0]          cnt_next;
  logic                btb_hit;

`ifdef BP_GSHARE_EN
  logic [GHR_BITS-1:0] ghr;

  always_ff @(posedge clk) begin
    if (reset)      ghr <= '0;
    else if (updEn) ghr <= GHR_BITS'({ghr, updTaken});
  end

  assign ghr_ext = 32'(ghr);
`else
  assign ghr_ext = '0;
`endif

  // Both paths hash with the pre-shift history, so update matches the lookup it trains.
  assign fetch_idx = IDX_BITS'(bp_hash(pcF, ghr_ext));
  assign upd_idx   = IDX_BITS'(bp_hash(updPc, ghr_ext));
  assign fetch_tag = pcF[IDX_BITS+2 +: TAG_BITS];
  assign upd_tag   = updPc[IDX_BITS+2 +: TAG_BITS];

  assign btb_hit     = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag);
  assign predTakenF  = btb_hit && pht[fetch_idx][1];
  assign predTargetF = predTakenF ? btb_target[fetch_idx] : pcF + 32'd4;

  bp_sat_counter u_cnt (
    .cnt      (pht[upd_idx]),
    .taken    (updTaken),
    .cnt_next (cnt_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) pht[i] <= WN;
      btb_valid <= '0;
    end else if (updEn) begin
      pht[upd_idx] <= cnt_next;
      if (updTaken) btb_valid[upd_idx] <= 1'b1;
    end
  end

  // Tag/target payload needs no reset; the valid bit guards it.
  always_ff @(posedge clk) begin
    if (!reset && updEn && updTaken) begin
      btb_tag[upd_idx]    <= upd_tag;
      btb_target[upd_idx] <= updTarget;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                        missCount <= '0;
    else if (updEn && updMispredict)  missCount <= missCount + 32'd1;
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with a per-cycle reference model.
module tb_branch_predictor;

  localparam int IDX_BITS = 6;
  localparam int GHR_BITS = 6;
  localparam int TAG_BITS = 8;
  localparam int N        = 1 << IDX_BITS;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pcF;
  logic        predTakenF;
  logic [31:0] predTargetF;
  logic        updEn;
  logic [31:0] updPc;
  logic        updTaken;
  logic [31:0] updTarget;
  logic        updMispredict;
  logic [31:0] missCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_BITS(IDX_BITS), .GHR_BITS(GHR_BITS), .TAG_BITS(TAG_BITS)) dut (
    .clk           (clk),
    .reset         (reset),
    .pcF           (pcF),
    .predTakenF    (predTakenF),
    .predTargetF   (predTargetF),
    .updEn         (updEn),
    .updPc         (updPc),
    .updTaken      (updTaken),
    .updTarget     (updTarget),
    .updMispredict (updMispredict),
    .missCount     (missCount)
  );

  // Reference model: counters as integers 0..3, BTB as plain arrays.
  int          m_cnt [N];
  bit          m_val [N];
  logic [31:0] m_tag [N];
  logic [31:0] m_tgt [N];
  logic [31:0] m_miss;
  int          m_ghr   = 0;
  bit          m_ready = 0;

  function automatic int midx(input logic [31:0] pc);
    logic [31:0] h;
`ifdef BP_GSHARE_EN
    h = (pc / 4) ^ 32'(m_ghr);
`else
    h = pc / 4;
`endif
    return int'(h % N);
  endfunction

  function automatic logic [31:0] mtag(input logic [31:0] pc);
    return (pc >> (IDX_BITS + 2)) % (1 << TAG_BITS);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = 1;
        m_val[i] = 0;
      end
      m_ghr   = 0;
      m_miss  = 0;
      m_ready = 1;
    end else if (updEn) begin
      int k;
      k = midx(updPc);
      if (updTaken) begin
        m_cnt[k] = (m_cnt[k] == 3) ? 3 : m_cnt[k] + 1;
        m_val[k] = 1;
        m_tag[k] = mtag(updPc);
        m_tgt[k] = updTarget;
      end else begin
        m_cnt[k] = (m_cnt[k] == 0) ? 0 : m_cnt[k] - 1;
      end
      if (updMispredict) m_miss = m_miss + 1;
      m_ghr = ((m_ghr * 2) + int'(updTaken)) % (1 << GHR_BITS);
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      int          k;
      bit          et;
      logic [31:0] eg;
      k  = midx(pcF);
      et = m_val[k] && (m_tag[k] == mtag(pcF)) && (m_cnt[k] >= 2);
      eg = et ? m_tgt[k] : pcF + 32'd4;
      chk("model_taken", 32'(predTakenF), 32'(et));
      chk("model_target", predTargetF, eg);
      chk("model_miss", missCount, m_miss);
    end
  end

  // Inputs change 2 time units after a rising edge and hold until the next one.
  task automatic drive(input bit en, input logic [31:0] pc, input bit tk,
                       input logic [31:0] tg, input bit mis);
    @(posedge clk);
    #2;
    updEn         = en;
    updPc         = pc;
    updTaken      = tk;
    updTarget     = tg;
    updMispredict = mis;
  endtask

  task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tg);
    drive(1'b1, pc, tk, tg, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic lit(input string name, input bit et, input logic [31:0] eg);
    #4;
    chk({name, "_taken"}, 32'(predTakenF), 32'(et));
    chk({name, "_target"}, predTargetF, eg);
  endtask

  initial begin
    // Update held during reset must be discarded.
    reset = 1'b1; pcF = 32'h40;
    updEn = 1'b1; updPc = 32'h40; updTaken = 1'b1; updTarget = 32'h80; updMispredict = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    updEn = 1'b0; updMispredict = 1'b0;
    lit("reset_lookup", 1'b0, 32'h44);
    chk("reset_miss", missCount, 32'd0);

    // Two taken updates train 0x40 -> 0x80.
    upd(32'h40, 1'b1, 32'h80);
    upd(32'h40, 1'b1, 32'h80);
    idle();
    pcF = 32'h40;
    lit("trained", 1'b1, 32'h80);

    // Same-cycle lookup sees the old entry; next cycle sees the new one.
    upd(32'h48, 1'b1, 32'h100);
    pcF = 32'h48;
    lit("same_cycle_old", 1'b0, 32'h4c);
    idle();
    lit("next_cycle_new", 1'b1, 32'h100);

    // Saturate at ST, then walk down with not-taken updates.
    pcF = 32'h40;
    upd(32'h40, 1'b1, 32'h80);
    upd(32'h40, 1'b0, 32'h0);
    upd(32'h40, 1'b0, 32'h0);
    lit("nt_after_1", 1'b1, 32'h80);
    upd(32'h40, 1'b0, 32'h0);
    lit("nt_after_2", 1'b0, 32'h44);
    upd(32'h40, 1'b0, 32'h0);
    idle();
    lit("nt_after_4", 1'b0, 32'h44);
    upd(32'h40, 1'b1, 32'h80);
    idle();
    lit("sn_plus_1", 1'b0, 32'h44);
    upd(32'h40, 1'b1, 32'h80);
    idle();
    lit("sn_plus_2", 1'b1, 32'h80);

    // Alias: same index, different tag.
    upd(32'h40, 1'b1, 32'h80);
    idle();
    pcF = 32'h40 + (32'd4 << IDX_BITS);
    lit("alias", 1'b0, 32'h144);
    pcF = 32'h40;
    lit("alias_owner", 1'b1, 32'h80);

    // Mixed pattern swept through the per-cycle model.
    for (int i = 0; i < 24; i++) begin
      upd(32'h1000 + 32'((i % 5) * 4), (i % 3) != 0, 32'h2000 + 32'(i * 16));
      pcF = 32'h1000 + 32'(((i + 1) % 5) * 4);
    end
    idle();

    // Miss counting: five qualifying updates, one ignored strobe.
    for (int k = 0; k < 5; k++) drive(1'b1, 32'h80 + 32'(k * 4), k[0], 32'h300, 1'b1);
    drive(1'b0, 32'h80, 1'b1, 32'h300, 1'b1);
    idle();
    #4;
    chk("miss_five", missCount, 32'd5);
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #4;
    chk("miss_after_reset", missCount, 32'd0);
    pcF = 32'h48;
    lit("post_reset_lookup", 1'b0, 32'h4c);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
